// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), one quotient bit per cycle.
// Optional early exit for zero divisor or |divisor| > |dividend| under `DIV_FAST_PATH_EN.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    input  logic             ack,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             stall_req
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               divz_q, divz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shifted, trial;
    logic               q_bit;
    logic [WIDTH-1:0]   iter_rem, iter_quo;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    assign a_mag = mag(dividend, sign);
    assign b_mag = mag(divisor, sign);

    // One restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
    assign shifted  = {prem_q, dvd_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvs_q};
    assign q_bit    = ~trial[WIDTH];
    assign iter_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign iter_quo = {dvd_q[WIDTH-2:0], q_bit};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divz_d    = divz_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_CALC;
                        cnt_d     = '0;
                        prem_d    = '0;
                        dvd_d     = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_d = sign & dividend[WIDTH-1];
                        zero_d    = (divisor == '0);
`ifdef DIV_FAST_PATH_EN
                        if ((divisor == '0) || (b_mag > a_mag)) begin
                            state_d = S_DONE;
                            quo_d   = (divisor == '0) ? '1 : '0;
                            rem_d   = dividend;
                            divz_d  = (divisor == '0);
                        end
`endif
                    end
                end
                S_CALC: begin
                    prem_d = iter_rem;
                    dvd_d  = iter_quo;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Last bit: apply sign fixup so results are registered on entering DONE.
                        state_d = S_DONE;
                        quo_d   = cond_neg(iter_quo, neg_quo_q & ~zero_q);
                        rem_d   = cond_neg(iter_rem, neg_rem_q);
                        divz_d  = zero_q;
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            divz_q  <= divz_d;
        end
    end

    always_ff @(posedge clk) begin
        prem_q    <= prem_d;
        dvd_q     <= dvd_d;
        dvs_q     <= dvs_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
        zero_q    <= zero_d;
    end

    assign busy      = (state_q == S_CALC);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = divz_q;
    assign stall_req = (start && (state_q == S_IDLE)) || busy;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: arithmetic model plus hand-computed vectors.
// Honours DIV_FAST_PATH_EN when predicting latency.
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] dvd = '0;
    logic [W-1:0] dvs = '0;
    logic         flush = 1'b0;
    logic         ack = 1'b0;
    logic         busy, out_valid, div_zero, stall_req;
    logic [W-1:0] quotient, remainder;

    int           n_chk = 0;
    int           n_fail = 0;

    logic [W-1:0] exp_q = '0;
    logic [W-1:0] exp_r = '0;
    logic         exp_dz = 1'b0;
    bit           exp_active = 1'b0;

    div_iter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sgn),
        .dividend  (dvd),
        .divisor   (dvs),
        .flush     (flush),
        .ack       (ack),
        .busy      (busy),
        .out_valid (out_valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    // Architectural result of DIV/DIVU, computed with wide integer arithmetic.
    task automatic model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end
    endtask

    function automatic bit fast_expected(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ma, mb;
        bit f;
        ma = (s && a[W-1]) ? -a : a;
        mb = (s && b[W-1]) ? -b : b;
        f  = (b == '0) || (mb > ma);
`ifndef DIV_FAST_PATH_EN
        f = 1'b0;
`endif
        return f;
    endfunction

    // Compare process: whenever a result is expected, outputs must match the model;
    // otherwise out_valid must stay low.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_active && out_valid) begin
                check("cmp_quotient", quotient, exp_q);
                check("cmp_remainder", remainder, exp_r);
                check("cmp_div_zero", W'(div_zero), W'(exp_dz));
            end else if (!exp_active) begin
                check("cmp_no_valid", W'(out_valid), '0);
            end
        end
    end

    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy);
        logic [W-1:0] mq, mr;
        logic mdz;
        model(s, a, b, mq, mr, mdz);
        exp_q = mq; exp_r = mr; exp_dz = mdz; exp_active = 1'b1;
        sgn = s; dvd = a; dvs = b; start = 1'b1;
        #1;
        check("stall_on_start", W'(stall_req), 1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_div(input string nm, input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lq, input logic [W-1:0] lr, input logic ldz);
        logic [W-1:0] mq, mr;
        logic mdz;
        int lat, nb;
        bit f;
        model(s, a, b, mq, mr, mdz);
        check({nm, "_model_q"}, mq, lq);
        check({nm, "_model_r"}, mr, lr);
        f = fast_expected(s, a, b);
        run_op(s, a, b, lat, nb);
        check({nm, "_latency"}, W'(lat), f ? 1 : W + 1);
        check({nm, "_busy_cycles"}, W'(nb), f ? 0 : W);
        check({nm, "_q"}, quotient, lq);
        check({nm, "_r"}, remainder, lr);
        check({nm, "_dz"}, W'(div_zero), W'(ldz));
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        exp_active = 1'b0;
        check({nm, "_idle_valid"}, W'(out_valid), 0);
        check({nm, "_idle_busy"}, W'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", W'(busy), 0);
        check("rst_valid", W'(out_valid), 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", W'(div_zero), 0);

        do_div("s19_m4", 1'b1, 32'd19, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0003, 1'b0);
        do_div("u_ffff_16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0);
        do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
        do_div("u7_0", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7, 1'b1);
        do_div("s_m20_0", 1'b1, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b1);
        do_div("u3_5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd3, 1'b0);
        do_div("s_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'hFFFF_FFFD, 1'b0);

        // Hold in DONE with ack low while inputs churn.
        run_op(1'b0, 32'd1000, 32'd7, lat, nb);
        check("hold_reach_valid", W'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            sgn = 1'($urandom); dvd = $urandom; dvs = $urandom; start = ~start;
            @(posedge clk); #1;
            check("hold_valid", W'(out_valid), 1);
            check("hold_q", quotient, 32'd142);
            check("hold_r", remainder, 32'd6);
        end
        start = 1'b0; ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; exp_active = 1'b0;
        check("hold_ack_valid", W'(out_valid), 0);
        check("hold_ack_busy", W'(busy), 0);

        // flush together with start in IDLE: no capture.
        sgn = 1'b0; dvd = 32'd50; dvs = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", W'(busy), 0);
        check("flush_start_valid", W'(out_valid), 0);

        // flush mid-CALC: abandon, results hold, no valid ever for that operation.
        sgn = 1'b0; dvd = 32'd1000; dvs = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("pre_flush_busy", W'(busy), 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", W'(busy), 0);
        check("flush_valid", W'(out_valid), 0);
        check("flush_q_held", quotient, 32'd142);
        repeat (40) begin
            @(posedge clk); #1;
        end
        check("flush_no_valid", W'(out_valid), 0);
        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Reset mid-CALC clears everything.
        sgn = 1'b0; dvd = 32'd999; dvs = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", W'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_busy", W'(busy), 0);
        check("mrst_valid", W'(out_valid), 0);
        check("mrst_q", quotient, 0);
        check("mrst_r", remainder, 0);
        check("mrst_dz", W'(div_zero), 0);
        check("mrst_stall", W'(stall_req), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
